multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Control FSM for a multicycle RV32I-subset datapath. It sequences fetch,
//   decode, address generation, memory access, execute and writeback. It also
//   traps any opcode or funct3 it does not support.
//
// Ports
//   clk, reset             : clock, synchronous active-high reset
//   opcode/funct3/funct7_5 : fields of the latched instruction
//   zero                   : ALU zero flag (branch condition)
//   mem_ready              : memory access completes this cycle
//   pc_write, ir_write,
//   reg_write, mem_write   : datapath strobes (forced low while reset=1)
//   adr_src, mem_req       : memory address select and access request
//   result_src, alu_src_a,
//   alu_src_b, alu_control : datapath mux selects and ALU operation
//   instr_type             : immediate format, decoded from opcode every cycle
//   illegal                : unsupported instruction trapped
// -----------------------------------------------------------------------------
package multicycle_controller_pkg;
  typedef enum logic [2:0] {
    IT_R = 3'd0,
    IT_I = 3'd1,
    IT_S = 3'd2,
    IT_B = 3'd3,
    IT_J = 3'd4,
    IT_U = 3'd5
  } instr_type_enum;
endpackage

module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic [6:0]     opcode,
  input  logic [2:0]     funct3,
  input  logic           funct7_5,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           pc_write,
  output logic           adr_src,
  output logic           mem_req,
  output logic           mem_write,
  output logic           ir_write,
  output logic           reg_write,
  output logic [1:0]     result_src,
  output logic [1:0]     alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [2:0]     alu_control,
  output instr_type_enum instr_type,
  output logic           illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  // ALU operation for the execute states. SUB is only reachable from R-type.
  // funct3=011 has no operation here and traps, so ADD is a don't-care filler.
  function automatic logic [2:0] funct_alu(input logic [2:0] f3,
                                           input logic       f7_5,
                                           input logic       is_r);
    logic [2:0] op;
    case (f3)
      3'b000:  op = (is_r && f7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  state_e     state_q, state_d;
  logic       adr_src_q, adr_src_d;
  logic       mem_req_q, mem_req_d;
  logic       mem_write_en_q, mem_write_en_d;
  logic       reg_write_en_q, reg_write_en_d;
  logic [1:0] result_src_q, result_src_d;
  logic [1:0] alu_src_a_q, alu_src_a_d;
  logic [1:0] alu_src_b_q, alu_src_b_d;
  logic [2:0] alu_control_q, alu_control_d;
  logic       illegal_q, illegal_d;
  // State flags that gate the input-qualified strobes.
  logic       fetch_q, fetch_d;
  logic       branch_q, branch_d;
  logic       jal_q, jal_d;
  logic       branch_taken_s;

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LOAD) state_d = S_MEMREAD;
        else                   state_d = S_MEMWRITE;
      end
      S_MEMREAD: begin
        if (mem_ready) state_d = S_MEMWB;
        else           state_d = S_MEMREAD;
      end
      S_MEMWB: state_d = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready) state_d = S_FETCH;
        else           state_d = S_MEMWRITE;
      end
      S_EXEC_R, S_EXEC_I: begin
        if (funct3 == 3'b011) state_d = S_TRAP;
        else                  state_d = S_ALUWB;
      end
      S_ALUWB: state_d = S_FETCH;
      S_BRANCH: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) state_d = S_FETCH;
        else                                      state_d = S_TRAP;
      end
      S_JAL:   state_d = S_ALUWB;
      S_LUI:   state_d = S_ALUWB;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // Moore outputs for the state being entered, so they can be registered.
  // funct3/funct7_5 come from the latched instruction and are stable here.
  always_comb begin
    adr_src_d      = 1'b0;
    mem_req_d      = 1'b0;
    mem_write_en_d = 1'b0;
    reg_write_en_d = 1'b0;
    result_src_d   = 2'b00;
    alu_src_a_d    = 2'b00;
    alu_src_b_d    = 2'b00;
    alu_control_d  = ALU_ADD;
    illegal_d      = 1'b0;
    fetch_d        = 1'b0;
    branch_d       = 1'b0;
    jal_d          = 1'b0;
    case (state_d)
      S_FETCH: begin
        mem_req_d    = 1'b1;
        alu_src_b_d  = 2'b10;
        result_src_d = 2'b10;
        fetch_d      = 1'b1;
      end
      S_DECODE: begin
        alu_src_a_d = 2'b01;
        alu_src_b_d = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a_d = 2'b10;
        alu_src_b_d = 2'b01;
      end
      S_MEMREAD: begin
        adr_src_d = 1'b1;
        mem_req_d = 1'b1;
      end
      S_MEMWB: begin
        result_src_d   = 2'b01;
        reg_write_en_d = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_d      = 1'b1;
        mem_req_d      = 1'b1;
        mem_write_en_d = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_d   = 2'b10;
        alu_control_d = funct_alu(funct3, funct7_5, 1'b1);
      end
      S_EXEC_I: begin
        alu_src_a_d   = 2'b10;
        alu_src_b_d   = 2'b01;
        alu_control_d = funct_alu(funct3, funct7_5, 1'b0);
      end
      S_ALUWB: reg_write_en_d = 1'b1;
      S_BRANCH: begin
        alu_src_a_d   = 2'b10;
        alu_control_d = ALU_SUB;
        branch_d      = 1'b1;
      end
      S_JAL: begin
        alu_src_a_d = 2'b01;
        alu_src_b_d = 2'b10;
        jal_d       = 1'b1;
      end
      S_LUI:   alu_src_b_d = 2'b01;
      S_TRAP:  illegal_d   = 1'b1;
      default: illegal_d   = 1'b1;
    endcase
  end

  // State and registered output flops; reset lands directly in FETCH outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_FETCH;
      adr_src_q      <= 1'b0;
      mem_req_q      <= 1'b1;
      mem_write_en_q <= 1'b0;
      reg_write_en_q <= 1'b0;
      result_src_q   <= 2'b10;
      alu_src_a_q    <= 2'b00;
      alu_src_b_q    <= 2'b10;
      alu_control_q  <= ALU_ADD;
      illegal_q      <= 1'b0;
      fetch_q        <= 1'b1;
      branch_q       <= 1'b0;
      jal_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      adr_src_q      <= adr_src_d;
      mem_req_q      <= mem_req_d;
      mem_write_en_q <= mem_write_en_d;
      reg_write_en_q <= reg_write_en_d;
      result_src_q   <= result_src_d;
      alu_src_a_q    <= alu_src_a_d;
      alu_src_b_q    <= alu_src_b_d;
      alu_control_q  <= alu_control_d;
      illegal_q      <= illegal_d;
      fetch_q        <= fetch_d;
      branch_q       <= branch_d;
      jal_q          <= jal_d;
    end
  end

  // Immediate format follows opcode in every state, including TRAP.
  always_comb begin
    case (opcode)
      OP_R:         instr_type = IT_R;
      OP_LOAD, OP_I: instr_type = IT_I;
      OP_STORE:     instr_type = IT_S;
      OP_BRANCH:    instr_type = IT_B;
      OP_JAL:       instr_type = IT_J;
      OP_LUI:       instr_type = IT_U;
      default:      instr_type = IT_R;
    endcase
  end

  // Strobes qualified by mem_ready / zero. All are suppressed while reset is
  // high so that nothing architectural updates in a reset cycle.
  always_comb begin
    branch_taken_s = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
    pc_write  = !reset && ((fetch_q && mem_ready) || jal_q || (branch_q && branch_taken_s));
    ir_write  = !reset && fetch_q && mem_ready;
    reg_write = !reset && reg_write_en_q;
    mem_write = !reset && mem_write_en_q;
  end

  assign adr_src     = adr_src_q;
  assign mem_req     = mem_req_q;
  assign result_src  = result_src_q;
  assign alu_src_a   = alu_src_a_q;
  assign alu_src_b   = alu_src_b_q;
  assign alu_control = alu_control_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  logic [6:0]     opcode;
  logic [2:0]     funct3;
  logic           funct7_5;
  logic           zero;
  logic           mem_ready;
  logic           pc_write, adr_src, mem_req, mem_write, ir_write, reg_write;
  logic [1:0]     result_src, alu_src_a, alu_src_b;
  logic [2:0]     alu_control;
  instr_type_enum instr_type;
  logic           illegal;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_req(mem_req),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .instr_type(instr_type), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef enum {T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
                T_EXEC_R, T_EXEC_I, T_ALUWB, T_BRANCH, T_JAL, T_LUI, T_TRAP} tb_st_e;

  typedef struct packed {
    logic       pc_write, adr_src, mem_req, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_control;
    logic [2:0] instr_type;
    logic       illegal;
  } out_t;

  typedef struct {
    tb_st_e     st;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f75, mr, z, rs;
  } step_t;

  step_t plan[$];
  out_t  sb_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  localparam logic [6:0] OPR = 7'b0110011, OPI = 7'b0010011, OPL = 7'b0000011,
                         OPS = 7'b0100011, OPB = 7'b1100011, OPJ = 7'b1101111,
                         OPU = 7'b0110111, OPX = 7'b1111111;

  function automatic logic [2:0] it_of(input logic [6:0] op);
    case (op)
      OPR:      return 3'd0;
      OPL, OPI: return 3'd1;
      OPS:      return 3'd2;
      OPB:      return 3'd3;
      OPJ:      return 3'd4;
      OPU:      return 3'd5;
      default:  return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? 3'b001 : 3'b000;
      3'b001:  return 3'b110;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b101:  return 3'b111;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs for one cycle spent in state st with the given inputs.
  function automatic out_t model(input step_t s);
    out_t o = '0;
    o.instr_type = it_of(s.op);
    case (s.st)
      T_FETCH: begin
        o.mem_req = 1'b1; o.alu_src_b = 2'b10; o.result_src = 2'b10;
        o.ir_write = s.mr & ~s.rs; o.pc_write = s.mr & ~s.rs;
      end
      T_DECODE:   begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; end
      T_MEMADR:   begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; end
      T_MEMREAD:  begin o.adr_src = 1'b1; o.mem_req = 1'b1; end
      T_MEMWB:    begin o.result_src = 2'b01; o.reg_write = ~s.rs; end
      T_MEMWRITE: begin o.adr_src = 1'b1; o.mem_req = 1'b1; o.mem_write = ~s.rs; end
      T_EXEC_R:   begin o.alu_src_a = 2'b10; o.alu_control = alu_of(s.f3, s.f75); end
      T_EXEC_I:   begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; o.alu_control = alu_of(s.f3, 1'b0); end
      T_ALUWB:    o.reg_write = ~s.rs;
      T_BRANCH: begin
        o.alu_src_a = 2'b10; o.alu_control = 3'b001;
        o.pc_write = ~s.rs & (((s.f3 == 3'b000) & s.z) | ((s.f3 == 3'b001) & ~s.z));
      end
      T_JAL:  begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.pc_write = ~s.rs; end
      T_LUI:  o.alu_src_b = 2'b01;
      T_TRAP: o.illegal = 1'b1;
      default: o.illegal = 1'b1;
    endcase
    return o;
  endfunction

  function automatic out_t obs_now();
    out_t o;
    o.pc_write = pc_write; o.adr_src = adr_src; o.mem_req = mem_req;
    o.mem_write = mem_write; o.ir_write = ir_write; o.reg_write = reg_write;
    o.result_src = result_src; o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b;
    o.alu_control = alu_control; o.instr_type = instr_type; o.illegal = illegal;
    return o;
  endfunction

  task automatic push(input tb_st_e st, input logic [6:0] op, input logic [2:0] f3,
                      input logic f75, input logic mr, input logic z, input logic rs);
    step_t s;
    s.st = st; s.op = op; s.f3 = f3; s.f75 = f75; s.mr = mr; s.z = z; s.rs = rs;
    plan.push_back(s);
  endtask

  // Apply one cycle of stimulus and queue what the DUT must show for it.
  task automatic drive(input step_t s);
    opcode = s.op; funct3 = s.f3; funct7_5 = s.f75;
    mem_ready = s.mr; zero = s.z; reset = s.rs;
    sb_q.push_back(model(s));
  endtask

  task automatic push_alu(input logic [6:0] op, input logic [2:0] f3, input logic f75);
    push(T_FETCH, op, f3, f75, 1'b1, 1'b0, 1'b0);
    push(T_DECODE, op, f3, f75, 1'b1, 1'b0, 1'b0);
    push(op == OPR ? T_EXEC_R : T_EXEC_I, op, f3, f75, 1'b1, 1'b0, 1'b0);
    push(T_ALUWB, op, f3, f75, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    out_t e, o;
    reset = 1'b1; opcode = OPR; funct3 = 3'b000; funct7_5 = 1'b0;
    mem_ready = 1'b0; zero = 1'b0;
    @(posedge clk); #1;
    push(T_FETCH, OPR, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
    push(T_FETCH, OPR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    push(T_FETCH, OPR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    foreach (plan[i]) begin
      drive(plan[i]);
      @(negedge clk);
      e = sb_q.pop_front(); o = obs_now(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset step%0d %s: got %b required %b", i, plan[i].st.name(), o, e);
      end
      @(posedge clk); #1;
    end
    plan.delete();
  endtask

  task automatic test_alu_ops();
    out_t e, o;
    push_alu(OPR, 3'b000, 1'b0);   // add
    push_alu(OPR, 3'b000, 1'b1);   // sub
    push_alu(OPR, 3'b001, 1'b0);
    push_alu(OPR, 3'b010, 1'b0);
    push_alu(OPR, 3'b100, 1'b0);
    push_alu(OPR, 3'b101, 1'b0);
    push_alu(OPR, 3'b110, 1'b0);
    push_alu(OPR, 3'b111, 1'b0);
    push_alu(OPI, 3'b111, 1'b0);   // andi
    push_alu(OPI, 3'b000, 1'b1);   // addi: funct7_5 must not select SUB
    push_alu(OPI, 3'b101, 1'b0);
    foreach (plan[i]) begin
      drive(plan[i]);
      @(negedge clk);
      e = sb_q.pop_front(); o = obs_now(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL alu_ops step%0d %s: got %b required %b", i, plan[i].st.name(), o, e);
      end
      @(posedge clk); #1;
    end
    plan.delete();
  endtask

  task automatic test_load_store();
    out_t e, o;
    // lw: one fetch wait, then 3 wait cycles in MEMREAD
    push(T_FETCH, OPL, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    push(T_FETCH, OPL, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
    push(T_DECODE, OPL, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
    push(T_MEMADR, OPL, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) push(T_MEMREAD, OPL, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    push(T_MEMREAD, OPL, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
    push(T_MEMWB, OPL, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
    // sw with one write wait
    push(T_FETCH, OPS, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
    push(T_DECODE, OPS, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    push(T_MEMADR, OPS, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
    push(T_MEMWRITE, OPS, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    push(T_MEMWRITE, OPS, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
    foreach (plan[i]) begin
      drive(plan[i]);
      @(negedge clk);
      e = sb_q.pop_front(); o = obs_now(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL load_store step%0d %s: got %b required %b", i, plan[i].st.name(), o, e);
      end
      @(posedge clk); #1;
    end
    plan.delete();
  endtask

  task automatic test_branch_jal_lui();
    out_t e, o;
    for (int k = 0; k < 4; k++) begin
      logic [2:0] f3;
      logic       z;
      f3 = (k < 2) ? 3'b000 : 3'b001;
      z  = k[0];
      push(T_FETCH, OPB, f3, 1'b0, 1'b1, z, 1'b0);
      push(T_DECODE, OPB, f3, 1'b0, 1'b1, z, 1'b0);
      push(T_BRANCH, OPB, f3, 1'b0, 1'b1, z, 1'b0);
    end
    push(T_FETCH, OPJ, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    push(T_DECODE, OPJ, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    push(T_JAL, OPJ, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    push(T_ALUWB, OPJ, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    push(T_FETCH, OPU, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    push(T_DECODE, OPU, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    push(T_LUI, OPU, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    push(T_ALUWB, OPU, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    // unsupported branch funct3 traps; reset recovers
    push(T_FETCH, OPB, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0);
    push(T_DECODE, OPB, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0);
    push(T_BRANCH, OPB, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0);
    push(T_TRAP, OPB, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0);
    push(T_TRAP, OPB, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1);
    push(T_FETCH, OPB, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    // R-type funct3=011 traps from EXEC_R
    push(T_FETCH, OPR, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0);
    push(T_DECODE, OPR, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0);
    push(T_EXEC_R, OPR, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0);
    push(T_TRAP, OPR, 3'b011, 1'b0, 1'b1, 1'b0, 1'b1);
    push(T_FETCH, OPR, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0);
    foreach (plan[i]) begin
      drive(plan[i]);
      @(negedge clk);
      e = sb_q.pop_front(); o = obs_now(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL branch_jal_lui step%0d %s: got %b required %b", i, plan[i].st.name(), o, e);
      end
      @(posedge clk); #1;
    end
    plan.delete();
  endtask

  task automatic test_trap_and_reset();
    out_t e, o;
    push(T_FETCH, OPX, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    push(T_DECODE, OPX, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++)
      push(T_TRAP, OPX, 3'b000, 1'b0, logic'(k % 2), 1'b0, 1'b0);
    push(T_TRAP, OPX, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
    push(T_FETCH, OPS, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    // reset in MEMWRITE while mem_ready is low
    push(T_DECODE, OPS, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    push(T_MEMADR, OPS, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    push(T_MEMWRITE, OPS, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    push(T_MEMWRITE, OPS, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    push(T_FETCH, OPS, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    push(T_FETCH, OPS, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    foreach (plan[i]) begin
      drive(plan[i]);
      @(negedge clk);
      e = sb_q.pop_front(); o = obs_now(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL trap_reset step%0d %s: got %b required %b", i, plan[i].st.name(), o, e);
      end
      @(posedge clk); #1;
    end
    plan.delete();
  endtask

  initial begin
    reset = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_alu_ops();
    test_load_store();
    test_branch_jal_lui();
    test_trap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
